// File: rtl/johnson_pkg.sv
// Shared encodings for the Johnson-counter sequencer: command opcodes and FSM states.
package johnson_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR   = 2'b00,
    OP_RUN_FWD = 2'b01,
    OP_RUN_REV = 2'b10,
    OP_SEEK    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/johnson_core.sv
// Twisted-ring counter with a phase index tracking its position in forward order.
module johnson_core #(
  parameter  int WIDTH = 4,
  localparam int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count_out,
  output logic [PH_W-1:0]  phase
);

  // Ring length need not be a power of two, so phase wraps by explicit compare.
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * WIDTH - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out <= '0;
      phase     <= '0;
    end else if (clr) begin
      count_out <= '0;
      phase     <= '0;
    end else if (en) begin
      if (!dir) begin
        count_out <= {count_out[WIDTH-2:0], ~count_out[WIDTH-1]};
        phase     <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
      end else begin
        count_out <= {~count_out[0], count_out[WIDTH-1:1]};
        phase     <= (phase == '0) ? PH_LAST : phase - PH_ONE;
      end
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command sequencer: accepts CLEAR/RUN_FWD/RUN_REV/SEEK, steps the Johnson core, pulses done.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int STEP_W = 8,
  localparam int PH_W   = $clog2(2 * WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              hold,
  output logic [WIDTH-1:0]  count_out,
  output logic [PH_W-1:0]   phase,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
  // are both high; cmd_ready is high only in IDLE and nothing is queued otherwise.

  localparam logic [STEP_W-1:0] RING    = STEP_W'(2 * WIDTH);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  logic [STEP_W-1:0] remaining;
  logic              dir_q;
  logic              accept;
  logic              step_en;
  logic              clr;
  logic [STEP_W-1:0] phase_ext;
  logic [STEP_W-1:0] seek_dist;

  assign accept    = cmd_valid && cmd_ready;
  assign step_en   = (state == S_STEP) && !hold;
  assign clr       = accept && (op_t'(cmd_op) == OP_CLEAR);
  assign phase_ext = STEP_W'(phase);
  // Forward distance to the target; only meaningful when cmd_arg < RING.
  assign seek_dist = (cmd_arg >= phase_ext) ? (cmd_arg - phase_ext)
                                            : (cmd_arg + RING - phase_ext);

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (step_en),
    .dir       (dir_q),
    .clr       (clr),
    .count_out (count_out),
    .phase     (phase)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            cmd_ready <= 1'b0;
            case (op_t'(cmd_op))
              OP_RUN_FWD, OP_RUN_REV: begin
                dir_q <= (op_t'(cmd_op) == OP_RUN_REV);
                if (cmd_arg == '0) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                end else begin
                  remaining <= cmd_arg;
                  state     <= S_STEP;
                  busy      <= 1'b1;
                end
              end
              OP_SEEK: begin
                dir_q <= 1'b0;
                if (cmd_arg >= RING) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                  err   <= 1'b1;
                end else if (seek_dist == '0) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                end else begin
                  remaining <= seek_dist;
                  state     <= S_STEP;
                  busy      <= 1'b1;
                end
              end
              default: begin
                state <= S_FIN;
                done  <= 1'b1;
              end
            endcase
          end
        end
        S_STEP: begin
          if (!hold) begin
            remaining <= remaining - STEP_ONE;
            if (remaining == STEP_ONE) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios plus randomized commands against a phase-based model.
module tb_johnson_seq_ctrl;
  import johnson_pkg::*;

  localparam int W    = 4;
  localparam int SW   = 8;
  localparam int PW   = $clog2(2 * W);
  localparam int RING = 2 * W;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [SW-1:0] cmd_arg;
  logic          hold;
  logic [W-1:0]  count_out;
  logic [PW-1:0] phase;
  logic          busy;
  logic          done;
  logic          err;
  state_t        state;

  johnson_seq_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .hold      (hold),
    .count_out (count_out),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state     (state)
  );

  // clock / reset
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           ph_q[$];
  int           m_phase = 0;
  logic [W-1:0] m_count = '0;

  // Johnson pattern at position p: p ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [W-1:0] johnson_of(input int p);
    int v;
    int mask;
    mask = (1 << W) - 1;
    if (p <= W) v = (1 << p) - 1;
    else        v = (mask << (p - W)) & mask;
    return W'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command and follow it cycle by cycle until the done pulse has passed.
  task automatic run_cmd(input int op, input int arg, input int hold_after, input int hold_len,
                         input bit rnd_hold, input bit poke);
    int steps, dir, exp_err, left, done_steps, held, p;
    bit h, poked;
    steps = 0; dir = 1; exp_err = 0; done_steps = 0; held = 0; poked = 0;
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_count", 32'(count_out), 32'(m_count));
    check("idle_phase", 32'(phase), 32'(m_phase));
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_arg   = SW'(arg);
    case (op)
      0: begin m_phase = 0; m_count = '0; end
      1: steps = arg;
      2: begin steps = arg; dir = -1; end
      default: begin
        if (arg >= RING) exp_err = 1;
        else steps = (arg - m_phase + RING) % RING;
      end
    endcase
    p = m_phase;
    for (int i = 0; i < steps; i++) begin
      p = (p + dir + RING) % RING;
      exp_q.push_back(johnson_of(p));
      ph_q.push_back(p);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    left = steps;
    while (left > 0) begin
      check("step_busy", 32'(busy), 32'd1);
      check("step_ready", 32'(cmd_ready), 32'd0);
      check("step_done", 32'(done), 32'd0);
      check("step_count", 32'(count_out), 32'(m_count));
      check("step_phase", 32'(phase), 32'(m_phase));
      if (rnd_hold) h = (held < 20) && ($urandom_range(0, 3) == 0);
      else          h = (done_steps >= hold_after) && (held < hold_len);
      if (h) held++;
      hold = h;
      if (poke && !poked && done_steps >= 1) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'(OP_CLEAR);
        poked     = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!h) begin
        m_count = exp_q.pop_front();
        m_phase = ph_q.pop_front();
        left--;
        done_steps++;
      end
    end
    hold = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_err", 32'(err), 32'(exp_err));
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_ready", 32'(cmd_ready), 32'd0);
    check("fin_count", 32'(count_out), 32'(m_count));
    check("fin_phase", 32'(phase), 32'(m_phase));
    check("fin_steps", 32'(done_steps), 32'(steps));
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_err", 32'(err), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
    check("post_count", 32'(count_out), 32'(m_count));
  endtask

  initial begin
    int op, arg;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; hold = 1'b0;
    #15 reset = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));

    // abort a RUN_FWD 10 after three steps
    cmd_valid = 1'b1; cmd_op = 2'(OP_RUN_FWD); cmd_arg = SW'(10);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_count", 32'(count_out), 32'(johnson_of(3)));
    #2 reset = 1'b0;
    #1;
    check("abort_count", 32'(count_out), 32'd0);
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
    end
    m_phase = 0; m_count = '0;

    run_cmd(1, 9, 0, 0, 0, 0);       // forward through the wrap, ends at phase 1
    check("fwd9_phase", 32'(m_phase), 32'd1);
    run_cmd(2, 3, 0, 0, 0, 0);       // reverse through 0 to 6
    run_cmd(3, 2, 0, 0, 0, 0);       // seek forward 4 steps to phase 2
    check("seek_count", 32'(count_out), 32'b0011);
    run_cmd(3, 2, 0, 0, 0, 0);       // seek to current phase: no motion
    run_cmd(3, 8, 0, 0, 0, 0);       // out-of-range target: err
    run_cmd(1, 4, 2, 3, 0, 0);       // hold for 3 cycles after E2
    run_cmd(1, 5, 0, 0, 0, 1);       // CLEAR while busy is ignored
    run_cmd(0, 0, 0, 0, 0, 0);       // CLEAR
    run_cmd(1, 0, 0, 0, 0, 0);       // zero-length runs
    run_cmd(2, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op == 3) arg = $urandom_range(0, 11);
      else         arg = $urandom_range(0, 20);
      run_cmd(op, arg, 0, 0, 1, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
